// File: rtl/cpu_instr_sequencer.sv
// Program-memory instruction source for simple_cpu: steps a PC and holds each word per opcode class.
// Optional CPU_SEQ_SINGLE_STEP_EN adds a `step` input that gates advancing past an expired hold.
module cpu_instr_sequencer #(
  parameter int unsigned INSTR_WIDTH    = 20,
  parameter int unsigned PROG_ADDR_BITS = 5,
  parameter int unsigned ALU_HOLD       = 3,
  parameter int unsigned MEM_HOLD       = 3,
  parameter int unsigned LOAD_HOLD      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      prog_we,
  input  logic [PROG_ADDR_BITS-1:0] prog_addr,
  input  logic [INSTR_WIDTH-1:0]    prog_wdata,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic                      step,
`endif
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic                      instr_valid,
  output logic [PROG_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      halted
);

  localparam int unsigned Depth = 2 ** PROG_ADDR_BITS;
  localparam int unsigned CntW  = 8;

  typedef enum logic [1:0] {StIdle, StIssue, StHalt} state_e;

  state_e                    state_q, state_d;
  logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
  logic                      valid_q, valid_d;
  logic [PROG_ADDR_BITS-1:0] pc_q, pc_d;
  logic [CntW-1:0]           cnt_q, cnt_d;

  logic [INSTR_WIDTH-1:0]    mem [Depth];
  logic                      mem_we;
  logic                      adv;
  logic                      step_ok;
  logic [PROG_ADDR_BITS-1:0] next_addr;
  logic [INSTR_WIDTH-1:0]    next_word;

`ifdef CPU_SEQ_SINGLE_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  // Counter is loaded with hold-1 so a word stays on the bus exactly `hold` cycles.
  function automatic logic [CntW-1:0] hold_m1(input logic [1:0] op);
    case (op)
      2'b10:   return CntW'(LOAD_HOLD - 1);
      2'b11:   return CntW'(MEM_HOLD - 1);
      default: return CntW'(ALU_HOLD - 1);
    endcase
  endfunction

  assign next_word = mem[next_addr];

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    adv       = 1'b0;
    next_addr = pc_q;

    case (state_q)
      StIdle, StHalt: begin
        // start has priority: a coincident write is dropped.
        if (start) begin
          adv       = 1'b1;
          next_addr = '0;
        end else if (prog_we) begin
          mem_we = 1'b1;
        end
      end
      StIssue: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (step_ok) begin
          adv       = 1'b1;
          next_addr = pc_q + PROG_ADDR_BITS'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (adv) begin
      pc_d = next_addr;
      if (next_word == '0) begin
        state_d = StHalt;
        instr_d = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end else begin
        state_d = StIssue;
        instr_d = next_word;
        valid_d = 1'b1;
        cnt_d   = hold_m1(next_word[INSTR_WIDTH-1 -: 2]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      instr_q <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Program memory is deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[prog_addr] <= prog_wdata;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = (state_q == StIssue);
  assign halted      = (state_q == StHalt);

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Directed bench for cpu_instr_sequencer: hold timing, HALT, write gating, reset, PC wrap.
// Inputs change and outputs are sampled on the falling edge.
module tb_cpu_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [19:0] prog_wdata;
  logic [19:0] instruction;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        busy;
  logic        halted;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic        step;
`endif

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [19:0] Add0  = 20'h47000;
  localparam logic [19:0] Add1  = 20'h53000;
  localparam logic [19:0] Store = 20'hD80F0;
  localparam logic [19:0] Load  = 20'hB80F0;
  localparam logic [19:0] Other = 20'h6A000;

  cpu_instr_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_wdata  (prog_wdata),
`ifdef CPU_SEQ_SINGLE_STEP_EN
    .step        (step),
`endif
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_word(input logic [4:0] a, input logic [19:0] d);
    prog_we    = 1'b1;
    prog_addr  = a;
    prog_wdata = d;
    @(negedge clk);
    prog_we    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Word w at address p must be live for exactly n sampled cycles.
  task automatic expect_hold(input string tag, input logic [19:0] w, input logic [4:0] p,
                             input int n);
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_instr"}, instruction, w);
      check_eq({tag, "_pc"}, pc, p);
      check_eq({tag, "_valid"}, instr_valid, 1);
      check_eq({tag, "_busy"}, busy, 1);
      @(negedge clk);
    end
  endtask

  task automatic expect_halt(input string tag, input logic [4:0] p);
    check_eq({tag, "_instr"}, instruction, 0);
    check_eq({tag, "_valid"}, instr_valid, 0);
    check_eq({tag, "_pc"}, pc, p);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_halted"}, halted, 1);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    step       = 1'b1;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_eq("rst_instr", instruction, 0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_pc", pc, 0);

    // Two ADDs then HALT, loaded in IDLE
    write_word(5'd0, Add0);
    write_word(5'd1, Add1);
    write_word(5'd2, 20'h0);
    pulse_start();
    expect_hold("add_w0", Add0, 5'd0, 3);
    expect_hold("add_w1", Add1, 5'd1, 3);
    expect_halt("add_halt", 5'd2);

    // STORE (3 cycles), LOAD (4 cycles), loaded while HALT
    write_word(5'd0, Store);
    write_word(5'd1, Load);
    write_word(5'd2, 20'h0);
    pulse_start();
    expect_hold("st", Store, 5'd0, 3);
    expect_hold("ld", Load, 5'd1, 4);
    expect_halt("stld_halt", 5'd2);

    // Writes during ISSUE are ignored
    write_word(5'd0, Add0);
    write_word(5'd1, Add1);
    pulse_start();
    prog_we    = 1'b1;
    prog_addr  = 5'd1;
    prog_wdata = Other;
    expect_hold("we_w0", Add0, 5'd0, 3);
    prog_we    = 1'b0;
    expect_hold("we_w1_old", Add1, 5'd1, 3);
    expect_halt("we_halt", 5'd2);

    // start together with prog_we: start wins, write to addr 0 dropped
    start      = 1'b1;
    prog_we    = 1'b1;
    prog_addr  = 5'd0;
    prog_wdata = Other;
    @(negedge clk);
    start   = 1'b0;
    prog_we = 1'b0;
    expect_hold("ws_w0", Add0, 5'd0, 3);
    expect_hold("ws_w1", Add1, 5'd1, 3);
    expect_halt("ws_halt", 5'd2);

    // Reset mid-issue, then rerun with memory intact
    write_word(5'd2, Load);
    write_word(5'd3, 20'h0);
    pulse_start();
    expect_hold("drop_w0", Add0, 5'd0, 3);
    check_eq("pre_rst_instr", instruction, Add1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_instr", instruction, 0);
    check_eq("mid_rst_valid", instr_valid, 0);
    check_eq("mid_rst_pc", pc, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_halted", halted, 0);
    pulse_start();
    expect_hold("rerun_w0", Add0, 5'd0, 3);
    expect_hold("rerun_w1", Add1, 5'd1, 3);
    expect_hold("rerun_w2", Load, 5'd2, 4);
    expect_halt("rerun_halt", 5'd3);

    // 32 ADD words, no HALT: pc wraps 31 -> 0 and keeps running
    for (int i = 0; i < 32; i++) begin
      write_word(5'(i), 20'h40000 | 20'(i + 1));
    end
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      expect_hold("wrap", 20'h40000 | 20'(i + 1), 5'(i), 3);
    end
    check_eq("wrap_pc", pc, 0);
    check_eq("wrap_busy", busy, 1);
    check_eq("wrap_instr", instruction, 20'h40001);

`ifdef CPU_SEQ_SINGLE_STEP_EN
    // Without step the expired word is held; a single pulse advances once
    step = 1'b0;
    expect_hold("ss_hold", 20'h40001, 5'd0, 10);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    expect_hold("ss_adv", 20'h40002, 5'd1, 6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
